// File: rtl/lbm_cell_reader.sv
// lbm_cell_reader: scans all lattice cells, reduces the nine RAM populations to rho/jx/jy per cell.
// Optional macro LBM_READER_BARRIER_MASK_EN zeroes the sums of solid cells.
module lbm_cell_reader #(
   parameter int DATA_WIDTH    = 16,
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 64,
   parameter int ADDRESS_WIDTH = 6
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_start,
   input  logic [DEPTH-1:0]              i_barriers,
   output logic [ADDRESS_WIDTH-1:0]      o_rd_address,
   input  logic [9*DATA_WIDTH-1:0]       i_f_data,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_out_valid,
   input  logic                          i_out_ready,
   output logic [ADDRESS_WIDTH-1:0]      o_out_index,
   output logic [DATA_WIDTH+3:0]         o_out_rho,
   output logic signed [DATA_WIDTH+2:0]  o_out_jx,
   output logic signed [DATA_WIDTH+2:0]  o_out_jy
);
   typedef enum logic [2:0] {IDLE, READ, CAPTURE, OUTPUT, DONE} state_t;
   state_t                     r_state, w_state_next;
   logic [ADDRESS_WIDTH-1:0]   r_index;
   logic [DATA_WIDTH-1:0]      w_f [9];
   logic [DATA_WIDTH+3:0]      w_rho;
   logic [DATA_WIDTH+2:0]      w_px, w_nx, w_py, w_ny;
   logic                       w_last, w_xfer, w_mask, w_unused;

   // f_data order: C0,N,NE,E,SE,S,SW,W,NW from the LSBs up
   for (genvar g = 0; g < 9; g++) begin : g_unpack
      assign w_f[g] = i_f_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   always_comb begin
      w_rho = '0;
      for (int i = 0; i < 9; i++) w_rho += (DATA_WIDTH+4)'(w_f[i]);
   end

   assign w_px = (DATA_WIDTH+3)'(w_f[3]) + (DATA_WIDTH+3)'(w_f[2]) + (DATA_WIDTH+3)'(w_f[4]);
   assign w_nx = (DATA_WIDTH+3)'(w_f[7]) + (DATA_WIDTH+3)'(w_f[8]) + (DATA_WIDTH+3)'(w_f[6]);
   assign w_py = (DATA_WIDTH+3)'(w_f[1]) + (DATA_WIDTH+3)'(w_f[2]) + (DATA_WIDTH+3)'(w_f[8]);
   assign w_ny = (DATA_WIDTH+3)'(w_f[5]) + (DATA_WIDTH+3)'(w_f[4]) + (DATA_WIDTH+3)'(w_f[6]);

`ifdef LBM_READER_BARRIER_MASK_EN
   assign w_mask   = i_barriers[r_index];
   assign w_unused = (WIDTH == 0);
`else
   assign w_mask   = 1'b0;
   assign w_unused = ^i_barriers ^ (WIDTH == 0);
`endif

   assign w_last      = (r_index == ADDRESS_WIDTH'(DEPTH-1));
   assign w_xfer      = (r_state == OUTPUT) && i_out_ready;
   assign o_busy      = (r_state != IDLE);
   assign o_done      = (r_state == DONE);
   assign o_out_valid = (r_state == OUTPUT);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (i_start) w_state_next = READ;
         READ:    w_state_next = CAPTURE;
         CAPTURE: w_state_next = OUTPUT;
         OUTPUT:  if (i_out_ready) w_state_next = w_last ? DONE : READ;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_index      <= '0;
         o_rd_address <= '0;
         o_out_index  <= '0;
         o_out_rho    <= '0;
         o_out_jx     <= '0;
         o_out_jy     <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == IDLE) begin
            r_index <= '0;
            if (i_start) o_rd_address <= '0;
         end
         // address only moves when the next READ is entered
         if (w_xfer && !w_last) begin
            r_index      <= r_index + 1'b1;
            o_rd_address <= r_index + 1'b1;
         end
         if (r_state == CAPTURE) begin
            o_out_index <= r_index;
            o_out_rho   <= w_mask ? '0 : w_rho;
            o_out_jx    <= w_mask ? '0 : signed'(w_px - w_nx);
            o_out_jy    <= w_mask ? '0 : signed'(w_py - w_ny);
         end
      end
   end
endmodule

// File: tb/tb_lbm_cell_reader.sv
// tb_lbm_cell_reader: directed checks of scan timing, arithmetic, backpressure, reset and barriers.
module tb_lbm_cell_reader;
   logic          clk = 1'b0;
   logic          rst_n, start, out_ready, busy, done, out_valid;
   logic [63:0]   barriers;
   logic [5:0]    rd_address, out_index;
   logic [143:0]  f_data;
   logic [19:0]   out_rho;
   logic signed [18:0] out_jx, out_jy;
   logic [143:0]  mem [64];
   int            n_pass = 0, n_total = 0;

   lbm_cell_reader dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_barriers(barriers),
      .o_rd_address(rd_address), .i_f_data(f_data), .o_busy(busy), .o_done(done),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_index(out_index),
      .o_out_rho(out_rho), .o_out_jx(out_jx), .o_out_jy(out_jy)
   );

   always #5 clk = ~clk;

   // one-cycle-latency RAM model
   always @(posedge clk) f_data <= mem[rd_address];

   function automatic logic [143:0] pack(input logic [15:0] c0, n, ne, e, se, s, sw, w, nw);
      return {nw, w, sw, s, se, e, ne, n, c0};
   endfunction

   task automatic fill(input logic [15:0] v);
      for (int i = 0; i < 64; i++) mem[i] = pack(v, v, v, v, v, v, v, v, v);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_rec(input int idx, input int rho, input int jx, input int jy);
      chk("valid", 64'(out_valid), 64'd1);
      chk("index", 64'(out_index), 64'(idx));
      chk("rho", 64'(out_rho), 64'(rho));
      chk("jx", out_jx, 64'(jx));
      chk("jy", out_jy, 64'(jy));
   endtask

   task automatic restart();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; barriers = '0;
      fill(16'd1);
      // reset held with start toggling
      for (int i = 0; i < 4; i++) begin
         start = i[0];
         step();
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_valid", 64'(out_valid), 64'd0);
         chk("rst_done", 64'(done), 64'd0);
         chk("rst_addr", 64'(rd_address), 64'd0);
         chk("rst_index", 64'(out_index), 64'd0);
         chk("rst_rho", 64'(out_rho), 64'd0);
         chk("rst_jx", out_jx, 64'd0);
         chk("rst_jy", out_jy, 64'd0);
      end
      start = 1'b0;
      rst_n = 1'b1;
      step();
      // full uniform scan, ignored starts at 50 and 193, new scan at 194
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 195; c++) begin
         chk("scan_valid", 64'(out_valid), 64'(c >= 3 && c <= 192 && c % 3 == 0));
         chk("scan_done", 64'(done), 64'(c == 193));
         chk("scan_busy", 64'(busy), 64'((c >= 1 && c <= 193) || c == 195));
         chk("scan_addr", 64'(rd_address), 64'(c >= 195 ? 0 : c >= 190 ? 63 : (c - 1) / 3));
         if (c >= 3 && c <= 192 && c % 3 == 0) chk_rec(c / 3 - 1, 9, 0, 0);
         start = (c == 50 || c == 193 || c == 194);
         step();
      end
      start = 1'b0;
      // arithmetic, backpressure, mid-scan reset
      mem[0] = pack(0, 0, 10, 100, 0, 5, 0, 30, 0);
      mem[1] = pack(0, 0, 0, 0, 0, 0, 0, 200, 0);
      mem[2] = pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      restart();
      run(2);
      chk_rec(0, 145, 80, 5);
      run(3);
      chk_rec(1, 200, -200, 0);
      run(3);
      chk_rec(2, 589815, 0, 0);
      run(15);
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk_rec(7, 9, 0, 0);
         chk("bp_addr", 64'(rd_address), 64'd7);
         if (i < 5) step();
      end
      out_ready = 1'b1;
      step();
      chk("bp_after_valid", 64'(out_valid), 64'd0);
      chk("bp_after_addr", 64'(rd_address), 64'd8);
      run(2);
      chk_rec(8, 9, 0, 0);
      run(6);
      chk_rec(10, 9, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_index", 64'(out_index), 64'd0);
      chk("mid_rst_addr", 64'(rd_address), 64'd0);
      chk("mid_rst_rho", 64'(out_rho), 64'd0);
      @(negedge clk);
      restart();
      run(2);
      chk_rec(0, 145, 80, 5);
      // barrier mask
      fill(16'd2);
      barriers[3] = 1'b1;
      restart();
      for (int k = 0; k < 5; k++) begin
         run(k == 0 ? 2 : 3);
`ifdef LBM_READER_BARRIER_MASK_EN
         chk_rec(k, k == 3 ? 0 : 18, 0, 0);
`else
         chk_rec(k, 18, 0, 0);
`endif
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
